// File: rtl/bitwise_op_arbiter.sv
`default_nettype none
// =============================================================================
// bitwise_op_arbiter : round-robin front end sharing one registered bitwise unit
// Rev 1.0
// =============================================================================
module bitwise_op_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 7,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_a,
  input  logic [N_REQ*DATA_W-1:0] i_req_b,
  input  logic [N_REQ*2-1:0]      i_req_op,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]       o_alu_a,
  output logic [DATA_W-1:0]       o_alu_b,
  output logic [1:0]              o_alu_op,
  input  logic [DATA_W-1:0]       i_alu_q,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_q,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic                    o_busy,
  output logic [15:0]             o_ops_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W-1:0]   w_rr_nxt;
  logic              w_grant_found;
  logic              w_accept;
  logic              w_rsp_hs;
  logic [N_REQ-1:0]  w_req_ready;
  int                w_idx;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [1:0]        r_alu_op;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_q;
  logic [ID_W-1:0]   r_rsp_id;
  logic [15:0]       r_ops_done;

  // Scan from the round-robin pointer upward, wrapping at N_REQ (not 2**ID_W).
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      if (!w_grant_found && i_req_valid[ID_W'(w_idx)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = ID_W'(w_idx);
      end
    end
  end

  assign w_rr_nxt = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_accept = (r_state == S_IDLE) && w_grant_found;
  assign w_rsp_hs = (r_state == S_RESP) && i_rsp_ready;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    w_req_ready = '0;
    if (w_accept && rst_n) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_found) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_CAPT;
      S_CAPT:  w_state_nxt = S_RESP;
      S_RESP:  if (i_rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= '0;
      r_rsp_id    <= '0;
      r_ops_done  <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= i_req_a[w_grant_idx*DATA_W +: DATA_W];
        r_alu_b  <= i_req_b[w_grant_idx*DATA_W +: DATA_W];
        r_alu_op <= i_req_op[w_grant_idx*2 +: 2];
        r_id     <= w_grant_idx;
        r_rr_ptr <= w_rr_nxt;
      end
      // The shared unit's result is only valid in CAPT; capture it there.
      if (r_state == S_CAPT) begin
        r_rsp_q     <= i_alu_q;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 16'd1;
      end
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_q     = r_rsp_q;
  assign o_rsp_id    = r_rsp_id;
  assign o_busy      = (r_state != S_IDLE);
  assign o_ops_done  = r_ops_done;

endmodule
`default_nettype wire
